// File: rtl/mmio_tx_port_pkg.sv
// mmio_tx_port_pkg: address map, status bit positions and status layout for mmio_tx_port
package mmio_tx_port_pkg;
  localparam logic [7:0] MMIO_TX_DATA_ADDR = 8'hF0;
  localparam logic [7:0] MMIO_TX_STAT_ADDR = 8'hF1;
  localparam int unsigned MMIO_TX_STAT_OVF_BIT = 56;
  localparam int unsigned MMIO_TX_STAT_EMPTY_BIT = 57;
  localparam int unsigned MMIO_TX_STAT_FULL_BIT = 58;
  localparam int unsigned MMIO_TX_STAT_COUNT_LSB = 63;
  typedef struct packed {
    logic [55:0] zero;
    logic        overflow;
    logic        empty;
    logic        full;
    logic [4:0]  count;
  } mmio_tx_status_t;
endpackage

// File: rtl/mmio_tx_port_fifo.sv
// sync_fifo: power-of-two depth FIFO with registered storage, wrapping pointers and occupancy count
module sync_fifo #(
  parameter int unsigned W = 64,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [0:W-1]             din,
  output logic [0:W-1]             dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  logic [0:W-1] mem_q [DEPTH];
  logic [0:W-1] mem_d [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  // next storage, pointers and count; pointers wrap naturally at the power-of-two depth
  always_comb begin
    mem_d = mem_q;
    mem_d[wr_q] = push ? din : mem_q[wr_q];
    wr_d = wr_q + AW'(push);
    rd_d = rd_q + AW'(pop);
    cnt_d = cnt_q + CW'(push) - CW'(pop);
  end
  // state registers; reset also clears storage so the head reads 0
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q <= '{default: '0};
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
    end
  end
  assign dout = mem_q[rd_q];
  assign count = cnt_q;
  assign full = cnt_q == CW'(DEPTH);
  assign empty = cnt_q == '0;
endmodule

// File: rtl/mmio_tx_port.sv
// mmio_tx_port: CPU-store-fed transmit FIFO with valid/ready output and status word; MMIO_TX_PARITY_EN adds tx_parity
module mmio_tx_port
  import mmio_tx_port_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter logic [7:0] DATA_ADDR = MMIO_TX_DATA_ADDR,
  parameter logic [7:0] STAT_ADDR = MMIO_TX_STAT_ADDR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [0:7]  addr,
  input  logic [0:63] write_data,
  input  logic        write_enable,
  output logic [0:63] read_data,
  output logic        hit,
  output logic [0:63] tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        tx_parity
);
  logic [$clog2(DEPTH):0] count;
  logic full, empty, push, pop, st_data, st_stat, overflow_q, overflow_d;
  mmio_tx_status_t stat;
  sync_fifo #(.W(64), .DEPTH(DEPTH)) u_fifo (
    .clk(clk), .rst(rst), .push(push), .pop(pop), .din(write_data),
    .dout(tx_data), .count(count), .full(full), .empty(empty)
  );
  // decode, handshake and sticky overflow; a pop frees the slot a same-cycle push needs
  always_comb begin
    st_data = write_enable && addr == DATA_ADDR;
    st_stat = write_enable && addr == STAT_ADDR;
    pop = !empty && tx_ready;
    push = st_data && (!full || pop);
    overflow_d = (st_data && full && !pop) ? 1'b1 : st_stat ? 1'b0 : overflow_q;
    stat = '0;
    stat.count = 5'(count);
    stat.full = full;
    stat.empty = empty;
    stat.overflow = overflow_q;
  end
  // overflow flag register
  always_ff @(posedge clk) begin
    overflow_q <= rst ? 1'b0 : overflow_d;
  end
  assign hit = addr == DATA_ADDR || addr == STAT_ADDR;
  assign read_data = addr == STAT_ADDR ? stat : '0;
  assign tx_valid = !empty;
`ifdef MMIO_TX_PARITY_EN
  assign tx_parity = ^tx_data;
`else
  assign tx_parity = 1'b0;
`endif
endmodule

// File: tb/tb_mmio_tx_port.sv
// tb_mmio_tx_port: queue-model bench with directed literal checks and randomized traffic
module tb_mmio_tx_port;
  localparam int DEPTH = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [0:7] addr = 8'h00;
  logic [0:63] write_data = '0;
  logic write_enable = 1'b0;
  logic tx_ready = 1'b0;
  logic [0:63] read_data, tx_data;
  logic hit, tx_valid, tx_parity;
  logic [63:0] q[$];
  bit ovf = 1'b0;
  bit chk_en = 1'b0;
  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mmio_tx_port dut (
    .clk(clk), .rst(rst), .addr(addr), .write_data(write_data),
    .write_enable(write_enable), .read_data(read_data), .hit(hit),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .tx_parity(tx_parity)
  );

  function automatic logic [63:0] status_of();
    return {56'b0, ovf, q.size() == 0, q.size() == DEPTH, 5'(q.size())};
  endfunction

  function automatic logic par_of(logic [63:0] w);
`ifdef MMIO_TX_PARITY_EN
    return ^w;
`else
    return 1'b0;
`endif
  endfunction

  task automatic cmp(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // reference model: queue semantics, pop first so a full queue accepts a push alongside a pop
  always @(posedge clk) begin
    if (rst) begin
      q.delete();
      ovf = 1'b0;
    end else begin
      if (q.size() > 0 && tx_ready) void'(q.pop_front());
      if (write_enable && addr == 8'hF1) ovf = 1'b0;
      if (write_enable && addr == 8'hF0) begin
        if (q.size() < DEPTH) q.push_back(write_data);
        else ovf = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      cmp("tx_valid", tx_valid, q.size() > 0);
      if (q.size() > 0) begin
        cmp("tx_data", tx_data, q[0]);
        cmp("tx_parity", tx_parity, par_of(q[0]));
      end
      cmp("hit", hit, addr == 8'hF0 || addr == 8'hF1);
      cmp("read_data", read_data, addr == 8'hF1 ? status_of() : 64'h0);
    end
  end

  task automatic drive(logic r, logic we, logic [7:0] a, logic [63:0] d, logic rdy);
    rst = r;
    write_enable = we;
    addr = a;
    write_data = d;
    tx_ready = rdy;
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_stat(logic rdy);
    drive(1'b0, 1'b0, 8'hF1, 64'h0, rdy);
  endtask

  initial begin
    step();
    step();
    chk_en = 1'b1;
    idle_stat(1'b0);
    cmp("lit_reset_status", read_data, 64'h40);
    cmp("lit_reset_valid", tx_valid, 1'b0);
    drive(1'b0, 1'b1, 8'hF0, 64'hDEADBEEF_00000001, 1'b0);
    step();
    idle_stat(1'b0);
    cmp("lit_single_valid", tx_valid, 1'b1);
    cmp("lit_single_data", tx_data, 64'hDEADBEEF_00000001);
    cmp("lit_single_status", read_data, 64'h1);
    step();
    step();
    step();
    idle_stat(1'b1);
    step();
    idle_stat(1'b0);
    cmp("lit_single_drained", tx_valid, 1'b0);
    for (int i = 1; i <= 5; i++) begin
      drive(1'b0, 1'b1, 8'hF0, 64'(i), 1'b0);
      step();
    end
    idle_stat(1'b0);
    cmp("lit_fill_status", read_data, 64'hA4);
    for (int i = 1; i <= 4; i++) begin
      idle_stat(1'b1);
      cmp("lit_drain_word", tx_data, 64'(i));
      step();
    end
    drive(1'b0, 1'b1, 8'hF1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    step();
    idle_stat(1'b0);
    cmp("lit_ovf_cleared", read_data, 64'h40);
    for (int i = 11; i <= 14; i++) begin
      drive(1'b0, 1'b1, 8'hF0, 64'(i), 1'b0);
      step();
    end
    drive(1'b0, 1'b1, 8'hF0, 64'd9, 1'b1);
    step();
    idle_stat(1'b0);
    cmp("lit_full_pushpop_status", read_data, 64'h24);
    for (int i = 0; i < 4; i++) begin
      idle_stat(1'b1);
      cmp("lit_full_pushpop_word", tx_data, i == 3 ? 64'd9 : 64'(12 + i));
      step();
    end
    for (int i = 0; i < 40; i++) begin
      drive(1'b0, i % 2 == 0, 8'hF0, 64'(100 + i / 2), i % 2 == 1);
      step();
    end
    for (int i = 0; i < 6; i++) begin
      idle_stat(1'b1);
      step();
    end
    drive(1'b0, 1'b1, 8'hF0, 64'hA, 1'b0);
    step();
    drive(1'b0, 1'b1, 8'hF0, 64'hB, 1'b0);
    step();
    drive(1'b1, 1'b1, 8'hF0, 64'hC, 1'b1);
    step();
    idle_stat(1'b0);
    cmp("lit_reset_mid_status", read_data, 64'h40);
    cmp("lit_reset_mid_valid", tx_valid, 1'b0);
    drive(1'b0, 1'b1, 8'hF0, 64'h7, 1'b0);
    step();
    idle_stat(1'b1);
`ifdef MMIO_TX_PARITY_EN
    cmp("lit_parity_7", tx_parity, 1'b1);
`else
    cmp("lit_parity_7", tx_parity, 1'b0);
`endif
    step();
    drive(1'b0, 1'b1, 8'hF0, 64'h3, 1'b0);
    step();
    idle_stat(1'b1);
    cmp("lit_parity_3", tx_parity, 1'b0);
    step();
    for (int i = 0; i < 400; i++) begin
      int sel;
      logic [7:0] a;
      sel = $urandom_range(0, 3);
      a = sel == 0 ? 8'hF1 : sel == 3 ? 8'($urandom) : 8'hF0;
      drive($urandom_range(0, 63) == 0, 1'($urandom_range(0, 1)), a,
            {$urandom, $urandom}, 1'($urandom_range(0, 2) == 0));
      step();
    end
    idle_stat(1'b0);
    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
